stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
Parametrised game controller for the block-stacking game.
- Captures the moving block position on each stop press.
- Trims the captured block to its overlap with the row below and stores each placed row for display.
- Detects win (all rows stacked) and lose (zero overlap), and supports restart without a global reset.
- Sits between the block-motion generator (source of newBlockLoc) and the display/scoring logic.

Parameters:
ROW_W, 8, width in cells of one row bitmap
NUM_ROWS, 8, number of stackable rows; a win is declared after all NUM_ROWS rows are placed
LINE_W, $clog2(NUM_ROWS+1), width of the line counter
SCORE_W, 12, score accumulator width (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
enable  in  1  game-active qualifier; stop presses are ignored while low
stopBtn  in  1  debounced stop button, level; held high counts once
restart  in  1  single-cycle pulse; clears the stack and returns to IDLE from any state
newBlockLoc  in  ROW_W  current moving-block bitmap
rowSel  in  LINE_W  display read address
lineNum  out  LINE_W  number of rows placed so far
stackLoc  out  ROW_W  bitmap of the top placed row (the next row's allowed region)
rowData  out  ROW_W  stored bitmap of row rowSel, combinational read; 0 if rowSel >= NUM_ROWS
blockWidth  out  $clog2(ROW_W+1)  popcount of stackLoc
gameOver  out  1  high in LOSE
gameWon  out  1  high in WIN
score  out  SCORE_W  accumulated score

Behaviour:
- Reset (rst==0 at posedge):
  - lineNum=0, stackLoc=0, all stored rows=0, score=0, gameOver=0, gameWon=0.
  - State=IDLE; edge-detector history register=0.
- Press detection: press = stopBtn & ~stopBtn_q, where stopBtn_q is stopBtn registered every cycle. A button held high yields exactly one press.
- States: IDLE, PLAY, WIN, LOSE.
  - IDLE: go to PLAY when enable==1; nothing is captured in this cycle.
  - PLAY, on press with enable==1:
    - ovl = (lineNum==0) ? newBlockLoc : (newBlockLoc & stackLoc).
    - If ovl==0: go to LOSE; lineNum, stackLoc and rows are unchanged.
    - Else: row[lineNum]<=ovl, stackLoc<=ovl, lineNum<=lineNum+1.
    - If lineNum==NUM_ROWS-1 in the same cycle, go to WIN.
  - PLAY with enable==0: state is held and presses are discarded (no deferred capture).
  - WIN / LOSE: all game registers frozen; presses ignored.
- Latency: one cycle. A press sampled at posedge N is visible on lineNum/stackLoc/rowData/flags after posedge N.
- restart==1 (any state):
  - Same effect as reset except stopBtn_q keeps tracking stopBtn.
  - restart has priority over a simultaneous press.
- Output flags: gameOver and gameWon are decoded from state, never both high.
- Widths and boundaries:
  - lineNum saturates at NUM_ROWS.
  - newBlockLoc==0 on the first row is treated as zero overlap and gives LOSE.
  - Full-width newBlockLoc on row 0 is legal.
- rst low mid-game overrides everything on that edge.

Optional Feature:
Macro STACK_SCORE_EN.
- Defined:
  - Each successful placement adds popcount(ovl) to score.
  - A perfect placement (ovl==stackLoc, lineNum>0) adds ROW_W on top of that.
  - score saturates at all-ones.
  - restart and rst clear score.
- Not defined: score is tied to 0 and no accumulator or popcount adder is instantiated for scoring. blockWidth remains present in both builds.

Decomposition:
- Package stack_pkg: state encoding (IDLE/PLAY/WIN/LOSE), default ROW_W/NUM_ROWS constants, and a popcount function.
- Sub-module stop_edge_det: registers stopBtn and emits the one-cycle press pulse; reset clears its register.
- Row storage is a register array inside stack_ctrl; no RAM.

Test Plan:
- Reset then enable=1, press with newBlockLoc=8'b00111100 -> lineNum=1, stackLoc=8'b00111100, rowData(rowSel=0)=8'b00111100, blockWidth=4.
- Next press with newBlockLoc=8'b00011110 -> stackLoc=8'b00011100, lineNum=2, blockWidth=3; with STACK_SCORE_EN, score=4+3=7.
- Press with newBlockLoc=8'b11000000 over stackLoc=8'b00011100 -> gameOver=1, lineNum stays 2; further presses produce no change.
- Eight presses of 8'b00011000 on an aligned stack -> lineNum=8, gameWon=1 after the 8th press; with STACK_SCORE_EN, score=2+7*(2+8)=72.
- stopBtn held high for 5 cycles -> exactly one capture (lineNum increments by 1); enable=0 during a press -> no capture.
- restart asserted in the same cycle as a press while in PLAY with lineNum=3 -> next cycle IDLE, lineNum=0, all rowData=0, score=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and helpers for the block-stacking game controller.
package stack_pkg;

  localparam int DEF_ROW_W    = 8;
  localparam int DEF_NUM_ROWS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_WIN,
    ST_LOSE
  } state_e;

  // Counts set bits of a row bitmap zero-extended to 32 bits (ROW_W <= 32).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + {5'd0, v[i]};
  endfunction

endpackage

// File: rtl/stop_edge_det.sv
// Rising-edge detector for the stop button: a held button yields one press.
module stop_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/stack_ctrl.sv
// Block-stacking game controller: captures, trims and stores rows, flags win/lose.
// Optional scoring is compiled in with `define STACK_SCORE_EN.
module stack_ctrl import stack_pkg::*; #(
  parameter int ROW_W    = DEF_ROW_W,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int LINE_W   = $clog2(NUM_ROWS + 1),
  parameter int SCORE_W  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         stopBtn,
  input  logic                         restart,
  input  logic [ROW_W-1:0]             newBlockLoc,
  input  logic [LINE_W-1:0]            rowSel,
  output logic [LINE_W-1:0]            lineNum,
  output logic [ROW_W-1:0]             stackLoc,
  output logic [ROW_W-1:0]             rowData,
  output logic [$clog2(ROW_W+1)-1:0]   blockWidth,
  output logic                         gameOver,
  output logic                         gameWon,
  output logic [SCORE_W-1:0]           score
);

  localparam int BW_W = $clog2(ROW_W + 1);

  state_e                             state_q, state_d;
  logic [LINE_W-1:0]                  line_q, line_d;
  logic [ROW_W-1:0]                   stack_q, stack_d;
  logic [NUM_ROWS-1:0][ROW_W-1:0]     rows_q, rows_d;
  logic [ROW_W-1:0]                   ovl;
  logic                               press;
  logic                               place;

  stop_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (stopBtn),
    .press_o(press)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    stack_d = stack_q;
    rows_d  = rows_q;
    place   = 1'b0;
    // The first row has nothing beneath it, so the whole block is kept.
    ovl     = (line_q == '0) ? newBlockLoc : (newBlockLoc & stack_q);
    if (restart) begin
      state_d = ST_IDLE;
      line_d  = '0;
      stack_d = '0;
      rows_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (enable) state_d = ST_PLAY;
        ST_PLAY: begin
          if (enable && press && line_q != LINE_W'(NUM_ROWS)) begin
            if (ovl == '0) begin
              state_d = ST_LOSE;
            end else begin
              place   = 1'b1;
              stack_d = ovl;
              line_d  = line_q + 1'b1;
              for (int i = 0; i < NUM_ROWS; i++)
                if (line_q == LINE_W'(i)) rows_d[i] = ovl;
              if (line_q == LINE_W'(NUM_ROWS - 1)) state_d = ST_WIN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      stack_q <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      stack_q <= stack_d;
      rows_q  <= rows_d;
    end
  end

  always_comb begin
    rowData = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (rowSel == LINE_W'(i)) rowData = rows_q[i];
  end

  assign lineNum    = line_q;
  assign stackLoc   = stack_q;
  assign blockWidth = BW_W'(popcount(32'(stack_q)));
  assign gameOver   = (state_q == ST_LOSE);
  assign gameWon    = (state_q == ST_WIN);

`ifdef STACK_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;

  // A perfect placement earns a full-row bonus on top of the kept cells.
  always_comb begin
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(popcount(32'(ovl)))
              + ((line_q != '0 && ovl == stack_q) ? (SCORE_W+1)'(ROW_W) : '0);
    score_d   = score_q;
    if (restart)    score_d = '0;
    else if (place) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) score_q <= '0;
    else      score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized and directed bench for stack_ctrl against a behavioural game model.
module tb_stack_ctrl;

  localparam int ROW_W = 8, NUM_ROWS = 8, LINE_W = 4, BW_W = 4, SCORE_W = 12;
  localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;

  logic                clk = 1'b0;
  logic                rst, enable, stopBtn, restart;
  logic [ROW_W-1:0]    newBlockLoc;
  logic [LINE_W-1:0]   rowSel;
  logic [LINE_W-1:0]   lineNum;
  logic [ROW_W-1:0]    stackLoc, rowData;
  logic [BW_W-1:0]     blockWidth;
  logic                gameOver, gameWon;
  logic [SCORE_W-1:0]  score;

  stack_ctrl #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .LINE_W(LINE_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .stopBtn(stopBtn), .restart(restart),
    .newBlockLoc(newBlockLoc), .rowSel(rowSel), .lineNum(lineNum), .stackLoc(stackLoc),
    .rowData(rowData), .blockWidth(blockWidth), .gameOver(gameOver), .gameWon(gameWon),
    .score(score)
  );

  always #5 clk = ~clk;

  int         m_state, m_lines, m_score;
  logic [7:0] m_stack;
  logic [7:0] m_rows [NUM_ROWS];
  bit         m_prev;
  int         n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_state = M_IDLE; m_lines = 0; m_stack = '0; m_score = 0;
    for (int i = 0; i < NUM_ROWS; i++) m_rows[i] = '0;
  endtask

  task automatic model_update();
    bit         pr;
    logic [7:0] ov;
    pr = stopBtn && !m_prev;
    if (!rst) begin
      model_clear();
      m_prev = 1'b0;
      return;
    end
    m_prev = stopBtn;
    if (restart) begin
      model_clear();
      return;
    end
    case (m_state)
      M_IDLE: if (enable) m_state = M_PLAY;
      M_PLAY: if (enable && pr) begin
        ov = (m_lines == 0) ? newBlockLoc : (newBlockLoc & m_stack);
        if (ov == 0) m_state = M_LOSE;
        else begin
`ifdef STACK_SCORE_EN
          m_score += $countones(ov) + ((m_lines > 0 && ov == m_stack) ? ROW_W : 0);
          if (m_score > (1 << SCORE_W) - 1) m_score = (1 << SCORE_W) - 1;
`endif
          m_rows[m_lines] = ov;
          m_stack = ov;
          m_lines++;
          if (m_lines == NUM_ROWS) m_state = M_WIN;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [7:0] exp_row;
    exp_row = (rowSel < NUM_ROWS) ? m_rows[rowSel] : 8'h00;
    chk("lineNum", 32'(lineNum), 32'(m_lines));
    chk("stackLoc", 32'(stackLoc), 32'(m_stack));
    chk("rowData", 32'(rowData), 32'(exp_row));
    chk("blockWidth", 32'(blockWidth), 32'($countones(m_stack)));
    chk("gameOver", 32'(gameOver), 32'(m_state == M_LOSE));
    chk("gameWon", 32'(gameWon), 32'(m_state == M_WIN));
    chk("score", 32'(score), 32'(m_score));
  endtask

  task automatic step(input bit r, input bit en, input bit b, input bit rs,
                      input logic [7:0] blk, input logic [3:0] sel);
    @(negedge clk);
    rst = r; enable = en; stopBtn = b; restart = rs; newBlockLoc = blk; rowSel = sel;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic press(input logic [7:0] blk);
    step(1, 1, 1, 0, blk, 4'd0);
    step(1, 1, 0, 0, blk, 4'd0);
  endtask

  initial begin
    logic [7:0] blk;
    bit r, rs, en, b;
    rst = 0; enable = 0; stopBtn = 0; restart = 0; newBlockLoc = '0; rowSel = '0;
    model_clear();
    m_prev = 0;

    step(0, 0, 0, 0, 8'h00, 4'd0);
    step(0, 1, 1, 0, 8'hFF, 4'd0);
    chk("rst_line", 32'(lineNum), 0);
    chk("rst_flags", 32'({gameOver, gameWon}), 0);

    // Basic placement and trimming
    step(1, 1, 0, 0, 8'h00, 4'd0);
    press(8'b00111100);
    chk("tp1_line", 32'(lineNum), 1);
    chk("tp1_stack", 32'(stackLoc), 32'h3C);
    chk("tp1_row0", 32'(rowData), 32'h3C);
    chk("tp1_bw", 32'(blockWidth), 4);
    press(8'b00011110);
    chk("tp2_stack", 32'(stackLoc), 32'h1C);
    chk("tp2_line", 32'(lineNum), 2);
    chk("tp2_bw", 32'(blockWidth), 3);
`ifdef STACK_SCORE_EN
    chk("tp2_score", 32'(score), 7);
`endif
    press(8'b11000000);
    chk("tp3_over", 32'(gameOver), 1);
    chk("tp3_line", 32'(lineNum), 2);
    press(8'hFF);
    chk("tp3_frozen", 32'(stackLoc), 32'h1C);

    // Full aligned stack to a win
    step(1, 1, 0, 1, 8'h00, 4'd0);
    step(1, 1, 0, 0, 8'h00, 4'd0);
    for (int i = 0; i < NUM_ROWS; i++) press(8'b00011000);
    chk("tp4_line", 32'(lineNum), 8);
    chk("tp4_won", 32'(gameWon), 1);
`ifdef STACK_SCORE_EN
    chk("tp4_score", 32'(score), 72);
`endif

    // Held button counts once; disabled press is dropped
    step(1, 1, 0, 1, 8'h00, 4'd0);
    step(1, 1, 0, 0, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 8'hFF, 4'd0);
    step(1, 1, 0, 0, 8'hFF, 4'd0);
    chk("tp5_hold", 32'(lineNum), 1);
    step(1, 0, 1, 0, 8'hFF, 4'd0);
    step(1, 0, 0, 0, 8'hFF, 4'd0);
    step(1, 1, 0, 0, 8'hFF, 4'd0);
    chk("tp5_disabled", 32'(lineNum), 1);

    // Restart wins over a simultaneous press
    press(8'hFF);
    press(8'hFF);
    chk("tp6_pre", 32'(lineNum), 3);
    step(1, 1, 1, 1, 8'hFF, 4'd0);
    chk("tp6_line", 32'(lineNum), 0);
    chk("tp6_score", 32'(score), 0);
    for (int i = 0; i < NUM_ROWS; i++) begin
      step(1, 0, 0, 0, 8'h00, 4'(i));
      chk("tp6_row", 32'(rowData), 0);
    end
    step(1, 1, 1, 0, 8'hFF, 4'd0);
    chk("tp6_idle", 32'(lineNum), 0);
    step(1, 1, 0, 0, 8'hFF, 4'd0);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      rs = ($urandom_range(0, 59) == 0) || (m_state >= M_WIN && $urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 9) != 0);
      b  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: blk = 8'($urandom);
        1, 2: blk = m_stack;
        3: blk = 8'hFF;
        default: blk = $urandom_range(0, 1) ? (m_stack << 1) : (m_stack >> 1);
      endcase
      step(r, en, b, rs, blk, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
